// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus, extends load data, stalls while busy.
// Optional define MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
//
// state | meaning
// IDLE  | waiting for a valid load/store; stalls combinationally in the accept cycle
// REQ   | dmem_req held with latched addr/we/be/wdata until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// DONE  | one-cycle done pulse (bus_err on timeout, misaligned on trap), pipeline advances
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_en,
  input  logic        MemRW,
  input  logic [2:0]  funct3,
  input  logic [31:0] DataALU,
  input  logic [31:0] DataB,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        bus_err,
  output logic        misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [CNT_WIDTH:0] TMO = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);

  state_t               state, state_nxt;
  logic [31:0]          addr_q, data_q, load_data_q;
  logic                 we_q, err_q;
  logic [2:0]           f3_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic                 accept, tmo_hit, abort, trap;
  logic [31:0]          wdata_calc, load_ext;
  logic [3:0]           be_calc;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract = {24'h0, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extract = {16'h0, sh[15:0]};
      default: extract = w;
    endcase
  endfunction

  assign accept  = (state == IDLE) && valid_in && mem_en;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);
  // A response arriving in the timeout cycle still wins over the abort.
  assign abort   = tmo_hit && (((state == REQ) && !dmem_gnt) || ((state == WAIT) && !dmem_rvalid));
  assign load_ext = extract(f3_q, addr_q[1:0], dmem_rdata);

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  logic acc_byte, acc_half;
  always_comb begin
    acc_byte = MemRW ? (funct3 == 3'b000) : (funct3[1:0] == 2'b00);
    acc_half = MemRW ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
    trap     = acc_half ? DataALU[0] : (!acc_byte && (DataALU[1:0] != 2'b00));
  end
  assign misaligned = (state == DONE) && mis_q;
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = trap ? DONE : REQ;
      REQ:  if (dmem_gnt) state_nxt = we_q ? DONE : WAIT;
            else if (tmo_hit) state_nxt = DONE;
      WAIT: if (dmem_rvalid || tmo_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = data_q;
    if (we_q) begin
      case (f3_q)
        3'b000: begin
          be_calc    = 4'b0001 << addr_q[1:0];
          wdata_calc = {4{data_q[7:0]}};
        end
        3'b001: begin
          be_calc    = 4'b0011 << {addr_q[1], 1'b0};
          wdata_calc = {2{data_q[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = data_q;
        end
      endcase
    end
  end

  always_comb begin
    stall      = accept || (state == REQ) || (state == WAIT);
    done       = (state == DONE);
    bus_err    = (state == DONE) && err_q;
    dmem_req   = (state == REQ);
    dmem_we    = dmem_req && we_q;
    dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    dmem_be    = dmem_req ? be_calc : 4'b0000;
    dmem_wdata = dmem_we ? wdata_calc : 32'h0;
    load_data  = load_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          addr_q <= DataALU;
          data_q <= DataB;
          we_q   <= MemRW;
          f3_q   <= funct3;
          cnt_q  <= '0;
          err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          mis_q  <= trap;
`endif
        end
        REQ, WAIT: begin
          cnt_q <= cnt_inc[CNT_WIDTH-1:0];
          if ((state == WAIT) && dmem_rvalid) begin
            load_data_q <= load_ext;
          end else if (abort) begin
            err_q       <= 1'b1;
            load_data_q <= '0;
          end
        end
        DONE: begin
          err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          mis_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single accesses plus timeout, reset and trap sequences.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset, valid_in, mem_en, MemRW;
  logic [2:0]  funct3;
  logic [31:0] DataALU, DataB;
  logic        stall, done, bus_err, misaligned;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_en(mem_en), .MemRW(MemRW),
    .funct3(funct3), .DataALU(DataALU), .DataB(DataB), .stall(stall),
    .load_data(load_data), .done(done), .bus_err(bus_err), .misaligned(misaligned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input vec_t v, input string tag);
    valid_in = 1'b1; mem_en = 1'b1; MemRW = v.we; funct3 = v.f3;
    DataALU = v.addr; DataB = v.data;
    #1;
    chk({tag, " accept stall"}, 32'(stall), 32'd1);
    step();
    valid_in = 1'b0; mem_en = 1'b0;
    chk({tag, " req"}, 32'(dmem_req), 32'd1);
    chk({tag, " req stall"}, 32'(stall), 32'd1);
    chk({tag, " addr"}, dmem_addr, v.exp_addr);
    chk({tag, " be"}, 32'(dmem_be), 32'(v.exp_be));
    chk({tag, " we"}, 32'(dmem_we), 32'(v.we));
    if (v.we) chk({tag, " wdata"}, dmem_wdata, v.exp_wdata);
    for (int i = 0; i < v.gnt_dly; i++) step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    if (!v.we) begin
      chk({tag, " wait stall"}, 32'(stall), 32'd1);
      for (int i = 0; i < v.rv_dly; i++) step();
      dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
      step();
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " done stall"}, 32'(stall), 32'd0);
    chk({tag, " bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, " misaligned"}, 32'(misaligned), 32'd0);
    chk({tag, " load_data"}, load_data, v.exp_load);
    step();
    chk({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    f3      addr        data         rdata        g  r  exp_addr     be       wdata         load
    vecs[0]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h00000000};
    vecs[1]  = '{1'b0, 3'b000, 32'h202, 32'h0,        32'h00800000, 0, 1, 32'h200, 4'b1111, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h202, 32'h0,        32'h00800000, 1, 1, 32'h200, 4'b1111, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 3'b001, 32'h002, 32'h0,        32'h80011234, 0, 0, 32'h000, 4'b1111, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{1'b1, 3'b010, 32'h040, 32'hDEADBEEF, 32'h0,        2, 0, 32'h040, 4'b1111, 32'hDEADBEEF, 32'hFFFF8001};
    vecs[5]  = '{1'b0, 3'b010, 32'h004, 32'h0,        32'h80011234, 0, 0, 32'h004, 4'b1111, 32'h0,        32'h80011234};
    vecs[6]  = '{1'b1, 3'b001, 32'h012, 32'h0000BEEF, 32'h0,        0, 0, 32'h010, 4'b1100, 32'hBEEFBEEF, 32'h80011234};
    vecs[7]  = '{1'b0, 3'b101, 32'h010, 32'h0,        32'h12348001, 0, 0, 32'h010, 4'b1111, 32'h0,        32'h00008001};
    vecs[8]  = '{1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0, 0, 32'h000, 4'b1111, 32'h0,        32'h0000007F};
    vecs[9]  = '{1'b0, 3'b110, 32'h008, 32'h0,        32'hCAFEF00D, 0, 0, 32'h008, 4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[10] = '{1'b1, 3'b000, 32'h020, 32'h00001234, 32'h0,        0, 0, 32'h020, 4'b0001, 32'h34343434, 32'hCAFEF00D};

    reset = 1'b1; valid_in = 1'b0; mem_en = 1'b0; MemRW = 1'b0; funct3 = 3'b000;
    DataALU = 32'h0; DataB = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    step(); step();
    reset = 1'b0;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset req", 32'(dmem_req), 32'd0);
    chk("reset load_data", load_data, 32'h0);
    step();
    chk("stale rvalid after reset", 32'(done), 32'd0);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

    // mem_en low must not start an access
    valid_in = 1'b1; mem_en = 1'b0;
    #1;
    chk("no mem_en stall", 32'(stall), 32'd0);
    step();
    chk("no mem_en req", 32'(dmem_req), 32'd0);
    valid_in = 1'b0;

    for (int i = 0; i < 11; i++) do_access(vecs[i], $sformatf("v%0d", i));

`ifndef MISALIGN_TRAP_EN
    begin
      vec_t mv;
      mv = '{1'b1, 3'b010, 32'h106, 32'h11223344, 32'h0, 0, 0,
             32'h104, 4'b1111, 32'h11223344, 32'hCAFEF00D};
      do_access(mv, "misalign_sw");
    end
`endif

    // timeout: load never granted
    valid_in = 1'b1; mem_en = 1'b1; MemRW = 1'b0; funct3 = 3'b010; DataALU = 32'h30;
    step();
    valid_in = 1'b0; mem_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("tmo req cyc%0d", k), 32'(dmem_req), 32'd1);
      chk($sformatf("tmo no done cyc%0d", k), 32'(done), 32'd0);
      step();
    end
    chk("tmo done", 32'(done), 32'd1);
    chk("tmo bus_err", 32'(bus_err), 32'd1);
    chk("tmo load_data", load_data, 32'h0);
    chk("tmo req dropped", 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    step();
    chk("tmo late rvalid done", 32'(done), 32'd0);
    chk("tmo bus_err cleared", 32'(bus_err), 32'd0);
    step();
    chk("tmo late rvalid stall", 32'(stall), 32'd0);
    chk("tmo late rvalid load", load_data, 32'h0);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

    // load after timeout to give load_data a nonzero value before reset test
    begin
      vec_t rv;
      rv = '{1'b0, 3'b010, 32'h50, 32'h0, 32'h5A5A0F0F, 0, 0,
             32'h50, 4'b1111, 32'h0, 32'h5A5A0F0F};
      do_access(rv, "pre_reset_lw");
    end

    // reset while in WAIT
    valid_in = 1'b1; mem_en = 1'b1; MemRW = 1'b0; funct3 = 3'b000; DataALU = 32'h60;
    step();
    valid_in = 1'b0; mem_en = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("rst wait stall", 32'(stall), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst load_data", load_data, 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h000000FF;
    step();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk("rst rvalid no done", 32'(done), 32'd0);
    chk("rst rvalid load", load_data, 32'h0);

`ifdef MISALIGN_TRAP_EN
    begin
      vec_t tv;
      tv = '{1'b0, 3'b010, 32'h70, 32'h0, 32'hA1B2C3D4, 0, 0,
             32'h70, 4'b1111, 32'h0, 32'hA1B2C3D4};
      do_access(tv, "pre_trap_lw");
    end
    valid_in = 1'b1; mem_en = 1'b1; MemRW = 1'b0; funct3 = 3'b010; DataALU = 32'h6;
    #1;
    chk("trap accept stall", 32'(stall), 32'd1);
    chk("trap accept req", 32'(dmem_req), 32'd0);
    step();
    valid_in = 1'b0; mem_en = 1'b0;
    chk("trap done", 32'(done), 32'd1);
    chk("trap misaligned", 32'(misaligned), 32'd1);
    chk("trap req", 32'(dmem_req), 32'd0);
    chk("trap stall", 32'(stall), 32'd0);
    chk("trap bus_err", 32'(bus_err), 32'd0);
    chk("trap load_data", load_data, 32'hA1B2C3D4);
    step();
    chk("trap done cleared", 32'(done), 32'd0);
    chk("trap misaligned cleared", 32'(misaligned), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs: ALU address, store data, MemRW, funct3 and destination info.
- Drives a req/gnt/rvalid data-memory bus with byte enables and lane steering.
- Sign/zero-extends load data for writeback.
- Stalls the pipeline while an access is outstanding.
- Aborts hung accesses with a bus-error pulse after a timeout.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
valid_in  input  1  MEM-stage instruction valid
mem_en  input  1  instruction is a load or store
MemRW  input  1  1=store, 0=load
funct3  input  3  access size/sign (RV32I encoding)
DataALU  input  32  byte address
DataB  input  32  store data (rs2)
stall  output  1  freeze IF..EX/MEM registers
load_data  output  32  extended load result
done  output  1  one-cycle pulse, access complete
bus_err  output  1  one-cycle pulse with done on timeout
misaligned  output  1  see Optional Feature
dmem_req  output  1  bus request
dmem_we  output  1  write enable
dmem_addr  output  32  word address, bits[1:0]=0
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read word

Behaviour:
- Single clock clk; reset is synchronous, active-high, named reset.
- Reset values: state=IDLE, all outputs 0, timeout counter 0, load_data 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: accept when valid_in && mem_en, then go to REQ and latch address, data, MemRW and funct3. stall=1 combinationally in the accept cycle.
- REQ: dmem_req=1 with addr/we/be/wdata stable from the latched values until dmem_gnt.
  - gnt on a store: go to DONE.
  - gnt on a load: go to WAIT.
- WAIT: on dmem_rvalid, capture the extracted load into load_data and go to DONE.
- DONE: done=1, stall=0 (pipeline advances at this edge), then return to IDLE. No new accept in DONE.
- stall = (IDLE && accept) || REQ || WAIT.
- Latency: store 3 cycles minimum (accept, gnt, DONE); load 4 cycles minimum.
- dmem_gnt ignored outside REQ. dmem_rvalid ignored outside WAIT, including stale rvalid after reset or abort.
- Byte enables:
  - SB (000): be = 0001 << addr[1:0], wdata = {4{DataB[7:0]}}.
  - SH (001): be = 0011 << {addr[1],1'b0}, wdata = {2{DataB[15:0]}}.
  - SW and all other funct3: be = 1111, wdata = DataB.
- Loads: dmem_be=1111. The byte/half is selected by latched addr[1:0].
  - LB: sign-extend. LBU: zero-extend.
  - LH: sign-extend. LHU: zero-extend.
  - LW and undefined funct3 (011/110/111): full word.
- Timeout: counter clears on accept and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES:
  - go to DONE with bus_err=1 and load_data=0;
  - dmem_req drops on the next cycle.
- load_data holds its value until the next load completes. A store does not alter it.
- Reset mid-access: next edge returns to IDLE and clears all outputs. An in-flight bus response is then ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or word access with addr[1:0]!=0, is flagged in the accept cycle and never issued to the bus.
  - FSM goes directly to DONE: done=1, misaligned=1 for that one cycle, load_data unchanged.
  - stall=1 only in the accept cycle.
- Undefined: misaligned is tied 0. The address is truncated to its word address and the shifted enables are masked to 4 bits; no trap is raised.

Test Plan:
1. SB: DataALU=0x103, DataB=0xA5 -> dmem_addr=0x100, be=1000, wdata=0xA5A5A5A5; gnt immediate -> done on 3rd cycle; stall high for cycles 1-2 only.
2. LB: addr=0x202, rdata=0x00800000, rvalid 2 cycles after gnt -> load_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
3. LH: addr=0x2, rdata=0x8001_1234 -> 0xFFFF8001. LW -> 0x80011234. Store in between leaves load_data unchanged.
4. Timeout: TIMEOUT_CYCLES=4, gnt never asserted -> bus_err and done pulse after 4 cycles in REQ, load_data=0, then a late rvalid is ignored.
5. Reset asserted while in WAIT -> next cycle IDLE, stall=0, dmem_req=0; rvalid the following cycle produces no done.
6. With MISALIGN_TRAP_EN: LW at 0x6 -> no dmem_req, done+misaligned pulse 1 cycle after accept.
